// File: rtl/lin_form_pipe.sv
// Two-stage pipelined unsigned linear-form evaluator t = sum coef[i]*x[i] with a
// threshold hit flag, valid/ready handshakes on both sides and saturating result counters.
module lin_form_pipe #(
  parameter int WIDTH = 10,
  parameter int N     = 2,
  parameter int CNT_W = 32,
  localparam int SUM_W = 2*WIDTH + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   coef,
  input  logic [N*WIDTH-1:0]   x,
  input  logic [SUM_W-1:0]     thresh,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     t,
  output logic                 hit,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     hit_cnt
);

  localparam int PW = 2*WIDTH;

  logic                 s1_v;
  logic                 s2_v;
  logic                 s1_ce;
  logic                 s2_ce;
  logic                 accept;
  logic                 handoff;
  logic [N-1:0][PW-1:0] prod_d;
  logic [N-1:0][PW-1:0] prod_q;
  logic [SUM_W-1:0]     thresh_q;
  logic [SUM_W-1:0]     sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // in_ready is combinational from out_ready so a full pipe still streams at one sample per clock
  assign s2_ce     = !s2_v | out_ready;
  assign s1_ce     = !s1_v | s2_ce;
  assign in_ready  = s1_ce;
  assign accept    = in_valid & in_ready;
  assign handoff   = s2_v & out_ready;
  assign out_valid = s2_v;

  // Full-precision products: operands are widened before multiplying
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N; i++) begin
      prod_d[i] = {{WIDTH{1'b0}}, coef[i*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, x[i*WIDTH +: WIDTH]};
    end
  end

  // Zero-extended sum of the stage-1 products
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + {{(SUM_W-PW){1'b0}}, prod_q[i]};
    end
  end

  // Stage 1: products and threshold captured with the accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      prod_q   <= '0;
      thresh_q <= '0;
    end else if (s1_ce) begin
      s1_v     <= accept;
      prod_q   <= prod_d;
      thresh_q <= thresh;
    end else begin
      s1_v     <= s1_v;
    end
  end

  // Stage 2: result and hit flag, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      t    <= '0;
      hit  <= 1'b0;
    end else if (s2_ce) begin
      s2_v <= s1_v;
      t    <= sum;
      hit  <= (sum <= thresh_q);
    end else begin
      s2_v <= s2_v;
    end
  end

  // Saturating counters; clr takes priority over a simultaneous hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      hit_cnt    <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      hit_cnt    <= '0;
    end else if (handoff) begin
      sample_cnt <= sat_inc(sample_cnt, 1'b1);
      hit_cnt    <= sat_inc(hit_cnt, hit);
    end else begin
      sample_cnt <= sample_cnt;
      hit_cnt    <= hit_cnt;
    end
  end

endmodule

// File: tb/tb_lin_form_pipe.sv
// Self-checking bench for lin_form_pipe: directed and random traffic against a queue-based
// reference model, plus a second instance (N=4, CNT_W=3) for wide sums and counter saturation.
module tb_lin_form_pipe;

  typedef struct {
    longint t;
    bit     hit;
  } res_t;

  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, in_valid, in_ready, out_valid, out_ready, hit;
  logic [19:0] coef, x;
  logic [20:0] thresh, t;
  logic [31:0] sample_cnt, hit_cnt;

  logic        clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, hit_b;
  logic [39:0] coef_b, x_b;
  logic [21:0] thresh_b, t_b;
  logic [2:0]  sample_cnt_b, hit_cnt_b;

  int     vectors = 0;
  int     miscompares = 0;
  res_t   q[$];
  longint ref_sc = 0, ref_hc = 0;
  bit     stalled = 0, last_acc = 0;
  longint held_t = 0;
  bit     held_hit = 0;
  int     cyc = 0, ho_count = 0, ho_first = 0, ho_last = 0;

  always #5 clk = ~clk;

  lin_form_pipe #(.WIDTH(10), .N(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .coef(coef), .x(x), .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .t(t), .hit(hit), .sample_cnt(sample_cnt), .hit_cnt(hit_cnt)
  );

  lin_form_pipe #(.WIDTH(10), .N(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .coef(coef_b), .x(x_b), .thresh(thresh_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .t(t_b), .hit(hit_b), .sample_cnt(sample_cnt_b), .hit_cnt(hit_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint lf2(input logic [19:0] c, input logic [19:0] xv);
    return longint'(c[9:0]) * longint'(xv[9:0]) + longint'(c[19:10]) * longint'(xv[19:10]);
  endfunction

  // One clock of the main instance: check outputs before the edge, update the model, check counters after
  task automatic step();
    bit   acc, ho;
    res_t r;
    r = '{t: 0, hit: 0};
    @(negedge clk);
    check("in_ready", in_ready, (q.size() == 2 && !out_ready) ? 0 : 1);
    if (stalled) begin
      check("hold_valid", out_valid, 1);
      check("hold_t", t, held_t);
      check("hold_hit", hit, held_hit);
    end
    stalled  = out_valid && !out_ready;
    held_t   = t;
    held_hit = hit;
    ho  = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (ho) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        r = q.pop_front();
        check("t", t, r.t);
        check("hit", hit, r.hit);
      end
      ho_count++;
      if (ho_count == 1) ho_first = cyc;
      ho_last = cyc;
      if (ref_sc < CMAX) ref_sc++;
      if (r.hit && ref_hc < CMAX) ref_hc++;
    end
    if (clr) begin
      ref_sc = 0;
      ref_hc = 0;
    end
    if (acc) begin
      r.t   = lf2(coef, x);
      r.hit = (r.t <= longint'(thresh));
      q.push_back(r);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    check("sample_cnt", sample_cnt, ref_sc);
    check("hit_cnt", hit_cnt, ref_hc);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    check("drained", q.size(), 0);
  endtask

  task automatic edge_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    coef = '0; x = '0; thresh = '0;
    clr_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    coef_b = '0; x_b = '0; thresh_b = '0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_t", t, 0);
    check("rst_hit", hit, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic sample and two-cycle latency
    coef = {10'd5, 10'd3}; x = {10'd2, 10'd7}; thresh = 21'd31; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    check("basic_t", t, 31);
    check("basic_hit", hit, 1);
    step();
    check("basic_sample_cnt", sample_cnt, 1);
    check("basic_hit_cnt", hit_cnt, 1);

    // Maximum operands
    coef = {10'd1023, 10'd1023}; x = {10'd1023, 10'd1023}; thresh = 21'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("max_t", t, 2093058);
    check("max_hit", hit, 0);
    drain();

    // Back-to-back stream of 8 without stall
    ho_count = 0;
    for (int k = 0; k < 8; k++) begin
      coef = 20'($urandom()); x = 20'($urandom()); thresh = 21'($urandom()); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("stream_count", ho_count, 8);
    check("stream_consecutive", ho_last - ho_first, 7);

    // Stream of 8 with a 3-cycle downstream stall
    sent = 0;
    last_acc = 1'b1;
    for (int k = 0; k < 20 && sent < 8; k++) begin
      if (last_acc) begin
        coef = 20'($urandom()); x = 20'($urandom()); thresh = 21'($urandom());
      end
      in_valid  = 1'b1;
      out_ready = !(k >= 3 && k <= 5);
      step();
      if (last_acc) sent++;
    end
    check("stall_sent", sent, 8);
    drain();

    // Randomised traffic with occasional clr
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || last_acc) begin
        coef = 20'($urandom()); x = 20'($urandom()); thresh = 21'($urandom());
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      step();
    end
    clr = 1'b0;
    drain();

    // Asynchronous reset with both stages full
    coef = {10'd9, 10'd4}; x = {10'd8, 10'd6}; thresh = 21'd100;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_t", t, 0);
    check("arst_hit", hit, 0);
    check("arst_sample_cnt", sample_cnt, 0);
    check("arst_hit_cnt", hit_cnt, 0);
    q.delete();
    ref_sc = 0; ref_hc = 0; stalled = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    coef = {10'd5, 10'd3}; x = {10'd2, 10'd7}; thresh = 21'd30; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_t", t, 31);
    check("post_rst_hit", hit, 0);
    drain();

    // Second instance: N=4 maximum operands, then counter saturation at 7
    coef_b = '1; x_b = '1; thresh_b = 22'd0; in_valid_b = 1'b1;
    edge_b();
    thresh_b = '1;
    edge_b();
    check("b_max_valid", out_valid_b, 1);
    check("b_max_t", t_b, 4186116);
    check("b_max_hit", hit_b, 0);
    repeat (9) edge_b();
    in_valid_b = 1'b0;
    repeat (3) edge_b();
    check("b_sat_valid", out_valid_b, 0);
    check("b_sat_sample_cnt", sample_cnt_b, 7);
    check("b_sat_hit_cnt", hit_cnt_b, 7);

    // clr coinciding with a hand-off clears both counters
    in_valid_b = 1'b1;
    edge_b();
    in_valid_b = 1'b0;
    edge_b();
    check("b_clr_pending", out_valid_b, 1);
    clr_b = 1'b1;
    edge_b();
    clr_b = 1'b0;
    check("b_clr_sample_cnt", sample_cnt_b, 0);
    check("b_clr_hit_cnt", hit_cnt_b, 0);
    in_valid_b = 1'b1;
    edge_b();
    in_valid_b = 1'b0;
    repeat (2) edge_b();
    check("b_after_clr_sample_cnt", sample_cnt_b, 1);
    check("b_after_clr_hit_cnt", hit_cnt_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
